adc_sample_framer: RTL

- Downstream consumer of the ADC capture stage: takes 12-bit unsigned samples with a 1-cycle valid strobe (clk domain).
- Removes the mid-scale DC offset, decimates by block-averaging, and packs samples into fixed-length frames in a ping-pong buffer.
- Streams completed frames to the spectral stage (FFT) over a valid/ready interface with start/end-of-frame markers.

---
 rtl/shazam_audio_pkg.sv | 25 ++
 rtl/frame_buffer_dp_ram.sv | 24 ++
 rtl/adc_sample_framer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/shazam_audio_pkg.sv
// Shared constants and FSM state types for the ADC sample framing path.
package shazam_audio_pkg;

  localparam int unsigned ADC_W        = 12;
  localparam int unsigned ADC_MIDSCALE = 2048;
  localparam int unsigned SYS_CLK_HZ   = 50_000_000;
  localparam int unsigned SAMPLE_W     = 13;

  typedef enum logic {
    WrFill,
    WrDrop
  } wr_state_e;

  typedef enum logic [1:0] {
    RdIdle,
    RdPrime,
    RdStream
  } rd_state_e;

  // Unsigned ADC code to signed offset-free sample; mod-2^13 arithmetic is exact here.
  function automatic logic signed [SAMPLE_W-1:0] remove_offset(input logic [ADC_W-1:0] code);
    return $signed({1'b0, code}) - $signed(SAMPLE_W'(ADC_MIDSCALE));
  endfunction

endpackage

// File: rtl/frame_buffer_dp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
module frame_buffer_dp_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 13,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Offset removal, block-average decimation and ping-pong framing of ADC samples,
// streamed out over valid/ready with start/end-of-frame markers.
module adc_sample_framer
  import shazam_audio_pkg::*;
#(
  parameter int unsigned DECIM     = 4,
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADC_W-1:0]        sample_data,
  input  logic                    sample_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    overflow,
  output logic [15:0]             frames_dropped
);

  localparam int unsigned DecimLog2 = $clog2(DECIM);
  localparam int unsigned CntW      = (DecimLog2 > 0) ? DecimLog2 : 1;
  localparam int unsigned AccW      = SAMPLE_W + DecimLog2;
  localparam int unsigned IdxW      = $clog2(FRAME_LEN);
  localparam int unsigned AddrW     = IdxW + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DECIM - 1);

  // Decimator
  logic signed [SAMPLE_W-1:0] s;
  logic signed [AccW-1:0]     s_ext, acc_sum, acc_q, acc_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic signed [SAMPLE_W-1:0] dec_q, dec_d;
  logic                       dec_valid_q, dec_valid_d;

  // Writer
  wr_state_e       wr_state_q, wr_state_d;
  logic            wb_q, wb_d, wr_other;
  logic [IdxW-1:0] widx_q, widx_d, dcnt_q, dcnt_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     dropped_q, dropped_d;
  logic            wr_en, wr_done;

  // Shared bank status and reader
  logic [1:0]       full_q, full_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d, rd_other;
  logic [IdxW-1:0]  ridx_q, ridx_d;
  logic             rd_free, rd_avail, rd_next_avail;
  logic [AddrW-1:0] raddr;
  logic [SAMPLE_W-1:0] rdata;

  logic signed [SAMPLE_W-1:0] rd_sample;
  logic signed [OUT_W-1:0]    rd_ext;

  always_comb begin
    s           = remove_offset(sample_data);
    s_ext       = AccW'(s);
    acc_sum     = acc_q + s_ext;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    dec_valid_d = 1'b0;
    if (sample_valid) begin
      if (cnt_q == LastCnt) begin
        acc_d       = '0;
        cnt_d       = '0;
        dec_d       = SAMPLE_W'(acc_sum >>> DecimLog2);
        dec_valid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wb_d       = wb_q;
    widx_d     = widx_q;
    dcnt_d     = dcnt_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    wr_en      = 1'b0;
    wr_done    = 1'b0;
    wr_other   = ~wb_q;
    unique case (wr_state_q)
      WrFill: begin
        if (dec_valid_q) begin
          wr_en  = 1'b1;
          widx_d = widx_q + 1'b1;
          if (widx_q == LastIdx) begin
            wr_done = 1'b1;
            widx_d  = '0;
            // Either way the next target is the other bank: the older frame frees first.
            wb_d    = wr_other;
            if (full_q[wr_other] && !(rd_free && (rd_bank_q == wr_other))) begin
              wr_state_d = WrDrop;
              dcnt_d     = '0;
            end
          end
        end
      end
      WrDrop: begin
        if (dec_valid_q) begin
          if (!full_q[wb_q]) begin
            wr_en      = 1'b1;
            widx_d     = IdxW'(1);
            wr_state_d = WrFill;
          end else begin
            overflow_d = 1'b1;
            dcnt_d     = dcnt_q + 1'b1;
            if (dcnt_q == LastIdx) begin
              dcnt_d = '0;
              if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
              end
            end
          end
        end
      end
      default: wr_state_d = WrFill;
    endcase
  end

  // A bank completing this cycle counts as available so first output lands 2 cycles later.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_bank_d     = rd_bank_q;
    ridx_d        = ridx_q;
    rd_free       = 1'b0;
    rd_other      = ~rd_bank_q;
    raddr         = {rd_bank_q, ridx_q};
    rd_avail      = full_q[rd_bank_q] || (wr_done && (wb_q == rd_bank_q));
    rd_next_avail = full_q[rd_other] || (wr_done && (wb_q == rd_other));
    unique case (rd_state_q)
      RdIdle: begin
        if (rd_avail) begin
          rd_state_d = RdPrime;
        end
      end
      RdPrime: begin
        ridx_d     = '0;
        rd_state_d = RdStream;
      end
      RdStream: begin
        if (out_ready) begin
          if (ridx_q == LastIdx) begin
            rd_free    = 1'b1;
            rd_bank_d  = rd_other;
            ridx_d     = '0;
            rd_state_d = rd_next_avail ? RdPrime : RdIdle;
          end else begin
            ridx_d = ridx_q + 1'b1;
            raddr  = {rd_bank_q, ridx_d};
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (wr_done) begin
      full_d[wb_q] = 1'b1;
    end
    if (rd_free) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
      wr_state_q  <= WrFill;
      wb_q        <= 1'b0;
      widx_q      <= '0;
      dcnt_q      <= '0;
      overflow_q  <= 1'b0;
      dropped_q   <= '0;
      full_q      <= '0;
      rd_state_q  <= RdIdle;
      rd_bank_q   <= 1'b0;
      ridx_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      dec_valid_q <= dec_valid_d;
      wr_state_q  <= wr_state_d;
      wb_q        <= wb_d;
      widx_q      <= widx_d;
      dcnt_q      <= dcnt_d;
      overflow_q  <= overflow_d;
      dropped_q   <= dropped_d;
      full_q      <= full_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      ridx_q      <= ridx_d;
    end
  end

  frame_buffer_dp_ram #(
    .DEPTH(2 * FRAME_LEN),
    .WIDTH(SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr({wb_q, widx_q}),
    .wdata(dec_q),
    .raddr(raddr),
    .rdata(rdata)
  );

  // While stalled the read address is held, so rdata re-reads the same word.
  always_comb begin
    rd_sample = $signed(rdata);
    rd_ext    = OUT_W'(rd_sample);
    out_valid = (rd_state_q == RdStream);
    out_sof   = out_valid && (ridx_q == '0);
    out_eof   = out_valid && (ridx_q == LastIdx);
    out_data  = out_valid ? (rd_ext <<< (OUT_W - SAMPLE_W)) : '0;
  end

  assign overflow       = overflow_q;
  assign frames_dropped = dropped_q;

endmodule
